// File: rtl/fifo_arb2_pkg.sv
// Shared types and defaults for the two-producer FIFO access controller.
package fifo_arb2_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 4;
  localparam int HI_WM_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD     = 3'd3,
    ST_RD_RSP = 3'd4
  } state_t;
endpackage

// File: rtl/fifo_arb2_if.sv
// Producer/consumer/FIFO handshake bundle; slave is the arbiter's view.
interface fifo_arb2_if import fifo_arb2_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();
  logic              req0, req1;
  logic [DATA_W-1:0] data0, data1;
  logic              rd_req;
  logic              full, empty;
  logic              wr_ack, wr_err, rd_ack, rd_err;
  logic [CNT_W-1:0]  data_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] d_in;
  logic              gnt0, gnt1;
  logic              ack0, ack1, err0, err1;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rr_ptr;

  modport slave (
    input  req0, req1, data0, data1, rd_req, full, empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count, fifo_dout,
    output wr_en, rd_en, d_in, gnt0, gnt1, ack0, ack1, err0, err1,
           rd_valid, rd_data, rr_ptr
  );

  modport master (
    output req0, req1, data0, data1, rd_req, full, empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count, fifo_dout,
    input  wr_en, rd_en, d_in, gnt0, gnt1, ack0, ack1, err0, err1,
           rd_valid, rd_data, rr_ptr
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: rr_ptr only matters on a tie.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic any,
  output logic id
);
  assign any = req0 | req1;
  assign id  = (req0 && req1) ? rr_ptr : req1;
endmodule

// File: rtl/fifo_arb2.sv
// Two-producer / one-consumer access controller in front of the 8-entry FIFO.
module fifo_arb2 import fifo_arb2_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HI_WM  = HI_WM_DEF
) (
  input logic       clk,
  input logic       reset_n,
  fifo_arb2_if.slave bus
);
  state_t            state, state_nxt;
  logic              gid, rr_ptr_q;
  logic              wr_en_q, rd_en_q;
  logic [DATA_W-1:0] d_in_q;
  logic              pick_any, pick_id;
  logic              rd_hi, wr_go;
  logic              unused;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .id     (pick_id)
  );

  // Watermark bypass keeps a busy writer pair from starving the consumer.
  assign rd_hi = bus.rd_req && (bus.data_count >= CNT_W'(HI_WM));
  assign wr_go = (state == ST_IDLE) && (state_nxt == ST_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_hi)                            state_nxt = ST_RD;
        else if (pick_any && !bus.full)       state_nxt = ST_WR;
        else if (bus.rd_req && !bus.empty)    state_nxt = ST_RD;
      end
      ST_WR:     state_nxt = ST_WR_RSP;
      ST_WR_RSP: state_nxt = ST_IDLE;
      ST_RD:     state_nxt = ST_RD_RSP;
      ST_RD_RSP: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Enables are decoded from the next state so they leave a flop aligned with WR/RD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gid      <= 1'b0;
      rr_ptr_q <= 1'b0;
      d_in_q   <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      wr_en_q <= (state_nxt == ST_WR);
      rd_en_q <= (state_nxt == ST_RD);
      if (wr_go) begin
        gid    <= pick_id;
        d_in_q <= pick_id ? bus.data1 : bus.data0;
      end
      if (state == ST_WR_RSP) rr_ptr_q <= ~gid;
    end
  end

  always_comb begin
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.err0     = 1'b0;
    bus.err1     = 1'b0;
    bus.rd_valid = 1'b0;
    if (state == ST_WR || state == ST_WR_RSP) begin
      bus.gnt0 = ~gid;
      bus.gnt1 = gid;
    end
    if (state == ST_WR_RSP) begin
      bus.ack0 = ~gid & bus.wr_ack;
      bus.ack1 = gid  & bus.wr_ack;
      bus.err0 = ~gid & bus.wr_err;
      bus.err1 = gid  & bus.wr_err;
    end
    if (state == ST_RD_RSP) bus.rd_valid = bus.rd_ack;
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.d_in    = d_in_q;
  assign bus.rr_ptr  = rr_ptr_q;
  assign bus.rd_data = bus.fifo_dout;
  assign unused      = bus.rd_err;
endmodule

// File: doc/fifo_arb2.md
# fifo_arb2

Two-producer, one-consumer access controller for the team's 8-entry, 32-bit handshake FIFO. It arbitrates write requests from two producers with round-robin priority, schedules consumer reads against those writes, and drives the FIFO's `wr_en`, `rd_en` and `d_in`. It also routes the FIFO's ack and err handshakes back to the requester that owns the current transaction. It sits directly in front of the FIFO, and both blocks share `clk` and `reset_n`.

## Interface
Parameters:
- `DATA_W`, default 32: data width.
- `CNT_W`, default 4: width of the FIFO `data_count`.
- `HI_WM`, default 6: high watermark. At or above this occupancy, reads take priority over writes.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1 each  producer write requests; each is held until that producer's ack or err.
- `data0`, `data1`  in  DATA_W each  producer write data; each is held stable while its request is high.
- `rd_req`  in  1  consumer read request; held until `rd_valid`.
- `full`, `empty`  in  1 each  FIFO status flags.
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err`  in  1 each  FIFO handshake outputs.
- `data_count`  in  CNT_W  FIFO occupancy, 0 to 8.
- `fifo_dout`  in  DATA_W  FIFO registered read data.
- `wr_en`, `rd_en`  out  1 each  FIFO enables; registered.
- `d_in`  out  DATA_W  FIFO write data; registered.
- `gnt0`, `gnt1`  out  1 each  grant, high during the WR and WR_RSP states of the owning producer.
- `ack0`, `ack1`, `err0`, `err1`  out  1 each  one-cycle per-producer write response.
- `rd_valid`  out  1  one-cycle pulse marking valid `rd_data`.
- `rd_data`  out  DATA_W  data returned to the consumer.
- `rr_ptr`  out  1  identity of the producer currently holding priority.

## Operation
State register, 3 bits, with five states: IDLE=0, WR=1, WR_RSP=2, RD=3, RD_RSP=4.

IDLE priority order, first match wins:
1. If `rd_req` and `data_count` >= HI_WM, go to RD.
2. If (`req0` or `req1`) and not `full`, go to WR.
   - If both producers request, grant goes to the producer named by `rr_ptr`; otherwise to the sole requester.
   - On this edge, register `gid` (the granted producer's identity) and register `d_in` from that producer's data.
3. If `rd_req` and not `empty`, go to RD.
4. Otherwise stay in IDLE.

WR state:
- Assert `wr_en` for exactly one cycle and assert `gnt[gid]`.
- Then go to WR_RSP unconditionally.

WR_RSP state:
- `ack[gid]` = `wr_ack`; `err[gid]` = `wr_err`. These are combinational from state, `gid` and the FIFO flags.
- Set `rr_ptr` to the producer other than `gid`.
- Go to IDLE.

RD state:
- Assert `rd_en` for one cycle, then go to RD_RSP.

RD_RSP state:
- `rd_valid` = `rd_ack`.
- `rd_data` = `fifo_dout` (pass-through).
- Go to IDLE.

Boundary behaviour:
- No write is issued while `full`, and no read while `empty`. A request that is not granted is held by its source; it is never dropped and never reported as an error.
- The watermark read bypass prevents writers from starving the consumer.
- `err0` and `err1` fire only if the FIFO reports `wr_err`, for example if another agent has corrupted the FIFO state. The FSM still returns to IDLE and `rr_ptr` still advances.
- A request that drops before its ack or err is a protocol violation; the transaction issued to the FIFO still completes.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `gid`=0, `d_in`=0, and all enables, grants, acks, errs and `rd_valid` = 0.
- Reset asserted mid-transaction aborts immediately to these values. The FIFO resets on the same signal.
- Write latency: a request sampled at edge N produces `wr_en` in cycle N+1 and `ack` in cycle N+2. The requester may drop its request at edge N+3.
- Read latency: `rd_en` in cycle N+1, then `rd_valid` and `rd_data` in cycle N+2.
- Throughput is at most one FIFO operation every 3 cycles, counting the IDLE cycle.
- The FIFO flags are sampled in IDLE only. They are current there because every FIFO operation completes its response cycle before the FSM returns to IDLE.

## Structure
- Shared package holds the state encodings and the default values of DATA_W and HI_WM.
- One sub-module, `rr_pick2`: a combinational 2-way round-robin picker.
  - Inputs: `req0`, `req1`, `rr_ptr`.
  - Outputs: `any` (either request is high) and the granted producer's identity.

## Test plan
- Reset, then `req0`=1 with `data0`=32'hA5A5_0001: `wr_en` in cycle 2, `d_in`=32'hA5A5_0001, `ack0` pulse in cycle 3, `data_count` becomes 1, `rr_ptr`=1.
- `req0` and `req1` held high continuously: grants alternate 0, 1, 0, 1, and the FIFO holds data0, data1, data0, data1 in that order.
- Fill to 8 entries, then `req1`=1: no `wr_en` and no `gnt1` while `full`. After one read completes, the write issues and `ack1` follows.
- `data_count`=6, `req0`=1 and `rd_req`=1 in the same cycle: RD is chosen first, `rd_valid` returns the oldest word, and the write is issued next.
- `rd_req`=1 with the FIFO empty: no `rd_en` is ever driven. After one write completes, the read returns that word with `rd_valid`=1.
- `reset_n` pulled low during the WR state: all outputs are 0 asynchronously, state=IDLE, and after release the FIFO is empty and `ack0` never pulses.
